// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks: FSM encoding, digit limit
// and the output-width helper used for elaboration-time parameter checks.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int BCD_MAX = 9;

    // Smallest width able to hold every value 0 .. 10^n - 1.
    function automatic int bw_for_digits(input int n);
        longint lim;
        longint pow2;
        int     bits;
        lim  = 1;
        for (int i = 0; i < n; i++) lim = lim * 10;
        pow2 = 1;
        bits = 0;
        while (pow2 < lim) begin
            pow2 = pow2 * 2;
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/bcd2hex_if.sv
// Request/result bundle between a BCD source and the bcd2hex converter.
interface bcd2hex_if #(
    parameter int DIGITS = 2,
    parameter int BW     = 7
);
    // start is a level; its sampled rising edge requests one conversion and is
    // ignored while busy. done pulses for one cycle when bin_out/err update;
    // bin_out/err then hold until the next done.
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BW-1:0]         bin_out;
    logic                  err;

    modport master (output start, bcd_in, input busy, done, bin_out, err);
    modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/start_edge_det.sv
// Two-flop sampler on an asynchronous level request plus a one-cycle
// rising-edge pulse.
module start_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);
    logic st0;
    logic st1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st0 <= 1'b0;
            st1 <= 1'b0;
        end else begin
            st0 <= level;
            st1 <= st0;
        end
    end

    assign pulse = st0 & ~st1;
endmodule

// File: rtl/bcd2hex.sv
// Packed BCD to binary converter: multiply-by-ten accumulator stepping one
// digit per clock, most significant digit first.
module bcd2hex
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BW     = 7
) (
    input  logic       clk,
    input  logic       rst,
    bcd2hex_if.slave   bus,
    output state_t     dbg_state
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("bcd2hex: DIGITS must be 1..4");
    end
    if (BW < bw_for_digits(DIGITS)) begin : g_bad_bw
        $error("bcd2hex: BW too narrow for DIGITS");
    end

    state_t              state;
    state_t              state_n;
    logic                edge_p;
    logic [4*DIGITS-1:0] dreg;
    logic [BW-1:0]       acc;
    logic [CW-1:0]       cnt;
    logic                eflag;
    logic                busy_r;
    logic                done_r;
    logic [BW-1:0]       bin_r;
    logic                err_r;

    logic [3:0]          d;
    logic [BW+3:0]       acc_w;
    logic [BW+3:0]       acc_next;
    logic                last;

    start_edge_det u_start (
        .clk   (clk),
        .rst   (rst),
        .level (bus.start),
        .pulse (edge_p)
    );

    assign d        = dreg[4*DIGITS-1 -: 4];
    assign acc_w    = {4'b0000, acc};
    assign acc_next = (acc_w << 3) + (acc_w << 1) + {{BW{1'b0}}, d};
    assign last     = (cnt == CW'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (edge_p) state_n = CONV;
            CONV:    if (last)   state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dreg   <= '0;
            acc    <= '0;
            cnt    <= '0;
            eflag  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bin_r  <= '0;
            err_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (edge_p) begin
                        dreg   <= bus.bcd_in;
                        acc    <= '0;
                        cnt    <= '0;
                        eflag  <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                CONV: begin
                    acc  <= acc_next[BW-1:0];
                    dreg <= dreg << 4;
                    cnt  <= cnt + 1'b1;
                    // Invalid digits keep stepping so latency never depends on data.
                    if (d > 4'(BCD_MAX)) eflag <= 1'b1;
                end
                FIN: begin
                    bin_r  <= eflag ? '0 : acc;
                    err_r  <= eflag;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bin_out = bin_r;
    assign bus.err     = err_r;
    assign dbg_state   = state;
endmodule

// File: tb/tb_bcd2hex.sv
// Drives a 2-digit and a 3-digit converter from one shared start line and
// scores every done pulse against an arithmetic BCD reference.
module tb_bcd2hex;
    import bcd_pkg::*;

    logic   clk;
    logic   rst;
    logic   start;
    state_t dbg_a;
    state_t dbg_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_qb[$];

    bcd2hex_if #(.DIGITS(2), .BW(7))  ifa ();
    bcd2hex_if #(.DIGITS(3), .BW(10)) ifb ();

    assign ifa.start = start;
    assign ifb.start = start;

    bcd2hex #(.DIGITS(2), .BW(7)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave), .dbg_state(dbg_a)
    );
    bcd2hex #(.DIGITS(3), .BW(10)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave), .dbg_state(dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Result encoded as {err, 15-bit value}; invalid digits force value 0.
    function automatic logic [15:0] ref_conv(input logic [15:0] v, input int n);
        int val;
        int d;
        bit e;
        val = 0;
        e   = 0;
        for (int i = n - 1; i >= 0; i--) begin
            d = int'((v >> (4 * i)) & 16'h000F);
            if (d > 9) e = 1;
            val = val * 10 + d;
        end
        return e ? 16'h8000 : 16'(val);
    endfunction

    always @(negedge clk) begin
        if (!rst && ifa.done) begin
            if (exp_q.size() == 0) check("a_unexpected_done", 32'(ifa.done), 0);
            else check("a_result", {16'd0, ifa.err, 8'd0, ifa.bin_out}, 32'(exp_q.pop_front()));
        end
        if (!rst && ifb.done) begin
            if (exp_qb.size() == 0) check("b_unexpected_done", 32'(ifb.done), 0);
            else check("b_result", {16'd0, ifb.err, 5'd0, ifb.bin_out}, 32'(exp_qb.pop_front()));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy_a"}, 32'(ifa.busy), 0);
        check({tag, "_done_a"}, 32'(ifa.done), 0);
        check({tag, "_bin_a"},  32'(ifa.bin_out), 0);
        check({tag, "_err_a"},  32'(ifa.err), 0);
        check({tag, "_state_a"}, 32'(dbg_a), 32'(IDLE));
        check({tag, "_busy_b"}, 32'(ifb.busy), 0);
        check({tag, "_done_b"}, 32'(ifb.done), 0);
        check({tag, "_bin_b"},  32'(ifb.bin_out), 0);
        check({tag, "_state_b"}, 32'(dbg_b), 32'(IDLE));
    endtask

    // Called at a negedge; the following posedge is edge 0 for both DUTs.
    task automatic run(input string tag, input logic [7:0] va, input logic [11:0] vb,
                       input int hold, input bit disturb);
        bit seen_a;
        bit seen_b;
        seen_a     = 0;
        seen_b     = 0;
        ifa.bcd_in = va;
        ifb.bcd_in = vb;
        exp_q.push_back(ref_conv({8'd0, va}, 2));
        exp_qb.push_back(ref_conv({4'd0, vb}, 3));
        start = 1'b1;
        for (int k = 0; k < 16 && !(seen_a && seen_b); k++) begin
            @(negedge clk);
            if (k == 0) check({tag, "_busy_e0"}, 32'(ifa.busy), 0);
            if (k == 1) begin
                check({tag, "_busy_a_e1"}, 32'(ifa.busy), 1);
                check({tag, "_busy_b_e1"}, 32'(ifb.busy), 1);
            end
            if (disturb) begin
                if (k == 1) begin
                    start      = 1'b0;
                    ifa.bcd_in = 8'h11;
                    ifb.bcd_in = 12'h111;
                end
                if (k == 2) start = 1'b1;
            end else if (k == hold - 1) begin
                start = 1'b0;
            end
            if (ifa.done && !seen_a) begin
                seen_a = 1;
                check({tag, "_lat_a"}, k, 4);
                check({tag, "_busy_a_fin"}, 32'(ifa.busy), 0);
            end
            if (ifb.done && !seen_b) begin
                seen_b = 1;
                check({tag, "_lat_b"}, k, 5);
                check({tag, "_busy_b_fin"}, 32'(ifb.busy), 0);
            end
        end
        check({tag, "_seen_a"}, 32'(seen_a), 1);
        check({tag, "_seen_b"}, 32'(seen_b), 1);
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 5) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        ifa.bcd_in = '0;
        ifb.bcd_in = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        run("h59",  8'h59, 12'h999, 3, 0);
        run("h99",  8'h99, 12'h905, 2, 0);
        run("h00",  8'h00, 12'h000, 2, 0);
        run("h3A",  8'h3A, 12'h9F1, 3, 0);
        run("h07",  8'h07, 12'h007, 2, 0);
        run("dist", 8'h42, 12'h420, 3, 1);

        // Abort mid-conversion, then hold start across reset release.
        ifa.bcd_in = 8'h59;
        ifb.bcd_in = 12'h999;
        start      = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(ifa.busy), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        check("rst_no_done", 32'(ifa.done), 0);
        rst = 1'b0;
        run("rst_rel", 8'h27, 12'h123, 3, 0);

        for (int n = 0; n < 20; n++) begin
            run("rnd", {rand_digit(), rand_digit()},
                {rand_digit(), rand_digit(), rand_digit()},
                int'($urandom_range(2, 5)), 0);
        end

        check("a_queue_empty", exp_q.size(), 0);
        check("b_queue_empty", exp_qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd2hex.md
# bcd2hex

- Converts a packed multi-digit BCD value (default two digits, 00–99) into a binary value.
- Uses an iterative multiply-by-ten accumulator, one digit per clock.
- Conversion is triggered by a rising edge on `start`. A one-cycle `done` pulse accompanies the result.
- Used on the stopwatch/clock datapath to turn user-set BCD digits (preset minutes/seconds) back into binary counter load values.

## Interface
- `DIGITS`, default 2: number of BCD digits in `bcd_in`; legal range 1–4.
- `BW`, default 7: width of `bin_out`. Must satisfy 2^BW ≥ 10^DIGITS. Defaults give 0–99.
- `clk` in, 1 bit: the single clock; all state updates on its rising edge.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `start` in, 1 bit: level input. The rising edge (after 2-flop sampling) requests a conversion.
- `bcd_in` in, 4*DIGITS bits: packed BCD. The most significant digit is `bcd_in[4*DIGITS-1 -: 4]`. It is captured once, at load.
- `busy` out, 1 bit: high while a conversion is in progress.
- `done` out, 1 bit: one-cycle pulse when `bin_out`/`err` update.
- `bin_out` out, BW bits: converted binary value. It holds until the next completion.
- `err` out, 1 bit: high if any captured digit was greater than 9. It holds until the next completion.

## Operation
- **Start detect**
  - `st0 <= start`, `st1 <= st0` every cycle.
  - The edge condition is `st0 & ~st1`.
- **States:** IDLE, CONV, FIN.
- **IDLE**
  - On the edge condition: `dreg <= bcd_in`, `acc <= 0`, `cnt <= 0`, `eflag <= 0`, `busy <= 1`, then go to CONV.
- **CONV**, each cycle:
  - `d = dreg[MSD]`.
  - `acc <= (acc<<3) + (acc<<1) + d`, computed in BW+4 bits and truncated to BW.
  - If `d > 9` then `eflag <= 1`.
  - `dreg <= dreg << 4`; `cnt <= cnt + 1`.
  - When `cnt == DIGITS-1`, go to FIN.
- **FIN**, one cycle:
  - `bin_out <= eflag ? 0 : acc`; `err <= eflag`.
  - `done <= 1`; `busy <= 0`; go to IDLE.
- `done` is cleared in every cycle that is not the FIN→IDLE transition.
- Start edges arriving while in CONV or FIN are ignored: no restart and no queuing. A new request needs `start` to go low and high again after `busy` falls.
- `bcd_in` changes after load do not affect the conversion in flight.
- Any invalid digit forces `bin_out = 0` and `err = 1`. The remaining digits are still stepped, so latency is unchanged.
- **Reset**
  - All outputs are 0: `busy = 0`, `done = 0`, `bin_out = 0`, `err = 0`.
  - State is IDLE; `st0 = st1 = 0`; `acc`, `dreg`, `cnt`, `eflag` are 0.
  - Reset mid-conversion aborts with no `done`.
  - If `start` is held high through reset release, it produces an edge and starts a conversion.

## Timing
- Edge 0 is the first clock edge at which `st0` samples `start = 1`.
- Edge 1: load; `busy` rises.
- Edges 2 … DIGITS+1: one digit accumulated per edge.
- Edge DIGITS+2: `bin_out`/`err` valid; `done` high and `busy` low for that cycle.
- Edge DIGITS+3: `done` falls.
- With the default DIGITS=2, `done` is high 4 cycles after edge 0.
- Minimum `start` high time: 2 cycles.
- Maximum throughput: one conversion per DIGITS+4 cycles, since `start` must also be seen low.

## Structure
- **Shared package `bcd_pkg`:**
  - state encoding (IDLE/CONV/FIN);
  - `BCD_MAX = 9`;
  - a width function `bw_for_digits(n)`, used for an elaboration-time check of BW against DIGITS.
- **Sub-module `start_edge_det`:** the 2-flop sampler plus rising-edge pulse. It is reusable by `hex2bcd`-style blocks.
- **Top-level `bcd2hex`:** holds the FSM, digit shift register, accumulator and output registers.

## Test plan
- Reset, then `bcd_in=8'h59`, pulse `start` for 3 cycles → `busy=1` from edge 1; `done` for one cycle at edge 4; `bin_out=7'd59`, `err=0`.
- `bcd_in=8'h99` → `bin_out=99`. `bcd_in=8'h00` → `bin_out=0`, `done` still pulses.
- `bcd_in=8'h3A` → `err=1`, `bin_out=0`. Next conversion of `8'h07` → `err=0`, `bin_out=7`.
- Start re-pulsed during CONV, and `bcd_in` changed to `8'h11` after load of `8'h42` → exactly one `done`, with `bin_out=42`.
- Assert `rst` during CONV → all outputs 0 immediately, no `done`. Hold `start` high across release → conversion runs and `done` appears 4 cycles after the first sampling edge.
- Run with DIGITS=3, BW=10: `bcd_in=12'h999` → `bin_out=999`, with `done` at edge 5.
